pci_edu_mmio: RTL

BAR0 memory-space register target and compute engine for the PCI Edu device. It sits directly downstream of pci_busif, which decodes memory-space transactions hitting BAR0 and forwards single-dword accesses here. Provides the identification, liveness, factorial and interrupt registers. Drives intr_status, which feeds both pci_cfg (status bit 3) and the INTA# pin logic.

---
 rtl/pci_edu_mmio.sv | 116 +++++++++++
 1 files changed

// File: rtl/pci_edu_mmio.sv
// BAR0 register target for the PCI Edu device: ID, liveness, factorial engine and IRQ registers.
// Reads are combinational; all state updates on clk, cleared asynchronously by rst (active low).
module pci_edu_mmio #(
    parameter logic [31:0] DEV_ID        = 32'h010000ed,
    parameter logic [31:0] FACT_IRQ_MASK = 32'h00000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_enable,
    input  logic        mmio_iswrite,
    input  logic [5:0]  mmio_offset,
    input  logic [31:0] mmio_write_val,
    output logic [31:0] mmio_read_val,
    output logic        intr_status
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [5:0] IDX_ID       = 6'd0;
    localparam logic [5:0] IDX_LIVE     = 6'd1;
    localparam logic [5:0] IDX_FACT     = 6'd2;
    localparam logic [5:0] IDX_STATUS   = 6'd8;
    localparam logic [5:0] IDX_IRQ_STAT = 6'd9;
    localparam logic [5:0] IDX_IRQ_RAISE = 6'd24;
    localparam logic [5:0] IDX_IRQ_ACK  = 6'd25;

    state_t      state_q, state_d;
    logic [31:0] liveness_q, liveness_d;
    logic [31:0] fact_val_q, fact_val_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] irq_status_q, irq_status_d;
    logic        irq_en_q, irq_en_d;
    logic        intr_q, intr_d;
    logic        busy;
    logic        wr;

    assign busy        = (state_q == RUN);
    assign wr          = mmio_enable && mmio_iswrite;
    assign intr_status = intr_q;

    always_comb begin
        mmio_read_val = 32'h0;
        case (mmio_offset)
            IDX_ID:       mmio_read_val = DEV_ID;
            IDX_LIVE:     mmio_read_val = ~liveness_q;
            IDX_FACT:     mmio_read_val = fact_val_q;
            IDX_STATUS:   mmio_read_val = {24'h0, irq_en_q, 6'h0, busy};
            IDX_IRQ_STAT: mmio_read_val = irq_status_q;
            default:      mmio_read_val = 32'h0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        liveness_d   = liveness_q;
        fact_val_d   = fact_val_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        irq_status_d = irq_status_q;
        irq_en_d     = irq_en_q;
        intr_d       = |irq_status_q;

        if (wr && mmio_offset == IDX_LIVE)      liveness_d = mmio_write_val;
        if (wr && mmio_offset == IDX_STATUS)    irq_en_d = mmio_write_val[7];
        if (wr && mmio_offset == IDX_IRQ_RAISE) irq_status_d = irq_status_d | mmio_write_val;
        if (wr && mmio_offset == IDX_IRQ_ACK)   irq_status_d = irq_status_d & ~mmio_write_val;

        // Completion is applied after any ack so a same-edge ack cannot swallow it;
        // irq_en_q is the pre-edge value, so a same-edge status write does not matter.
        case (state_q)
            IDLE: begin
                if (wr && mmio_offset == IDX_FACT) begin
                    state_d    = RUN;
                    fact_val_d = mmio_write_val;
                    cnt_d      = mmio_write_val;
                    acc_d      = 32'd1;
                end
            end
            RUN: begin
                if (cnt_q > 32'd1 && acc_q != 32'd0) begin
                    acc_d = acc_q * cnt_q;
                    cnt_d = cnt_q - 32'd1;
                end else begin
                    fact_val_d = acc_q;
                    state_d    = IDLE;
                    if (irq_en_q) irq_status_d = irq_status_d | FACT_IRQ_MASK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            liveness_q   <= 32'h0;
            fact_val_q   <= 32'h0;
            acc_q        <= 32'h0;
            cnt_q        <= 32'h0;
            irq_status_q <= 32'h0;
            irq_en_q     <= 1'b0;
            intr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            liveness_q   <= liveness_d;
            fact_val_q   <= fact_val_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            irq_status_q <= irq_status_d;
            irq_en_q     <= irq_en_d;
            intr_q       <= intr_d;
        end
    end

endmodule
